ibex_hpm_unit: RTL and testbench
================================

# ibex_hpm_unit

Parametrised hardware performance monitor for the Ibex CSR file. It replaces fixed per-counter instantiation with a configurable bank of mhpmcounter3..N event counters. Each counter has its own mhpmevent selector, a mcountinhibit bit and a sticky overflow flag. It sits beside the CSR block, decodes its own CSR addresses, and returns read data and a hit indication to the CSR read mux.

## Interface
- NumCounters, 10, implemented counters (1..29), mapped to mhpmcounter3..3+NumCounters-1
- CounterWidth, 40, counter width in bits (32..64)
- NumEvents, 16, event inputs (1..32)
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- event_i  in  NumEvents  per-cycle event pulses from core
- csr_we_i  in  1  CSR write strobe (final value after set/clear resolution)
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  CSR write data
- csr_rdata_o  out  32  read data for csr_addr_i
- csr_hit_o  out  1  csr_addr_i decodes to a register of this unit
- ovf_irq_o  out  1  OR of all unmasked overflow flags

## Operation
- Address map: mhpmevent3+k at 12'h323+k; mhpmcounter3+k low at 12'hB03+k; high at 12'hB83+k; mcountinhibit at 12'h320; overflow status CSR_MHPMOVF at 12'h7C2.
- Only the 32-bit mcountinhibit bits [3+k] are handled here; other bits read 0 and are not written.
- mhpmevent3+k: NumEvents-bit mask, upper bits read 0; reset 0 (counter never counts).
- Increment rule per counter k: inc_k = !inhibit[3+k] && |(mhpmevent_k & event_i). Adds exactly 1 per cycle regardless of how many selected events fire.
- Low-half write replaces bits [31:0]; high-half write replaces bits [CounterWidth-1:32]. Bits above CounterWidth are ignored on write and read 0. With CounterWidth=32 the high half reads 0 and writes are dropped.
- Write vs increment, same cycle, same counter: written half takes csr_wdata_i; the untouched half keeps its value; no increment that cycle.
- Wrap: all-ones + 1 -> 0 and sets ovf[3+k] (sticky).
- CSR_MHPMOVF: write-1-to-clear at bits [3+k]. Set by wrap wins over a simultaneous clear.
- Unimplemented counter addresses (index >= 3+NumCounters, <=31) still hit, read 0, ignore writes.
- csr_hit_o is 0 for all other addresses; csr_rdata_o is 0 then.

## Timing
- Reset (rst_i high, asynchronous): all counters 0, all mhpmevent 0, mcountinhibit bits 0, overflow flags 0, ovf_irq_o 0.
- csr_rdata_o and csr_hit_o are combinational from csr_addr_i and present register state (value before this cycle's update).
- event_i is sampled at the rising edge; the counter shows the increment the following cycle (1-cycle latency).
- mhpmevent and mcountinhibit writes take effect for events from the next cycle; events in the write cycle use the old setting.
- ovf_irq_o is registered: it asserts the cycle after the wrapping increment is visible.
- Reset assertion mid-count clears state immediately; counting resumes the first cycle after deassertion.

## Configuration
- IBEX_HPM_OVF_IRQ_EN defined: overflow flags, CSR_MHPMOVF and ovf_irq_o are implemented as above.
- Not defined: no flag storage; 12'h7C2 does not hit; ovf_irq_o tied to 0. Counters wrap silently.

## Test plan
- Reset, then read 12'hB03 and 12'h323 -> 0. Pulse event_i[0] 5 cycles with mhpmevent3=0 -> counter stays 0.
- mhpmevent3=32'h3; assert event_i[0] and event_i[1] together for 4 cycles -> mhpmcounter3 reads 4 (not 8), visible 1 cycle after the last pulse.
- Continuous event; write low half 32'h10 in cycle n -> reads 32'h10 at n+1 and 32'h11 at n+2. High half is unchanged.
- CounterWidth=40: write high 32'hFF and low 32'hFFFFFFFF, then one event -> counter 0. With macro: 12'h7C2 bit3=1, ovf_irq_o high next cycle. Write 32'h8 to 12'h7C2 -> irq low.
- Set mcountinhibit bit4 with event active -> mhpmcounter4 frozen from the cycle after the write. mhpmcounter3 keeps counting.
- Read 12'hB1F with NumCounters=10 -> hit=1, data=0; read 12'h7C2 without macro -> hit=0.

Source files
------------

// File: rtl/ibex_hpm_unit.sv
// Configurable bank of mhpmcounter3..N event counters with per-counter event masks and inhibit bits.
// Define IBEX_HPM_OVF_IRQ_EN to add sticky overflow flags, the CSR_MHPMOVF register and ovf_irq_o.
module ibex_hpm_unit #(
  parameter int unsigned NumCounters  = 10,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumEvents-1:0] event_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  output logic                 ovf_irq_o
);

  logic [4:0] sel;
  logic       is_inh;
  logic       is_evt;
  logic       is_lo;
  logic       is_hi;

  // Low five address bits give the counter index 3..31 inside each 32-entry CSR window.
  assign sel    = csr_addr_i[4:0];
  assign is_inh = (csr_addr_i == 12'h320);
  assign is_evt = (csr_addr_i[11:5] == 7'h19) && (sel >= 5'd3);
  assign is_lo  = (csr_addr_i[11:5] == 7'h58) && (sel >= 5'd3);
  assign is_hi  = (csr_addr_i[11:5] == 7'h5C) && (sel >= 5'd3);

  logic [NumCounters-1:0]       inh_q;
  logic [NumCounters-1:0]       inh_d;
  logic [NumCounters-1:0]       inc;
  logic [NumCounters-1:0][31:0] rd_lo;
  logic [NumCounters-1:0][31:0] rd_hi;
  logic [NumCounters-1:0][31:0] rd_evt;
  logic [31:0]                  inh_word;

`ifdef IBEX_HPM_OVF_IRQ_EN
  logic                   is_ovf;
  logic [NumCounters-1:0] wrap;
  logic [NumCounters-1:0] ovf_q;
  logic [NumCounters-1:0] ovf_d;
  logic                   ovf_irq_q;
  logic                   ovf_irq_d;
  assign is_ovf = (csr_addr_i == 12'h7C2);
`endif

  for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
    localparam logic [4:0] Idx = 5'(k + 3);

    logic [CounterWidth-1:0] cnt_q;
    logic [CounterWidth-1:0] cnt_d;
    logic [CounterWidth-1:0] lo_repl;
    logic [CounterWidth-1:0] hi_repl;
    logic [NumEvents-1:0]    evt_q;
    logic [NumEvents-1:0]    evt_d;
    logic                    wr_lo;
    logic                    wr_hi;
    logic                    wr_evt;

    assign wr_lo  = csr_we_i && is_lo && (sel == Idx);
    assign wr_evt = csr_we_i && is_evt && (sel == Idx);

    if (CounterWidth > 32) begin : g_hi
      assign wr_hi    = csr_we_i && is_hi && (sel == Idx);
      assign lo_repl  = {cnt_q[CounterWidth-1:32], csr_wdata_i};
      assign hi_repl  = {csr_wdata_i[CounterWidth-33:0], cnt_q[31:0]};
      assign rd_hi[k] = 32'(cnt_q[CounterWidth-1:32]);
    end else begin : g_nohi
      // No upper half exists: high-half writes are dropped and reads return zero.
      assign wr_hi    = 1'b0;
      assign lo_repl  = csr_wdata_i;
      assign hi_repl  = cnt_q;
      assign rd_hi[k] = '0;
    end

    assign inc[k]    = !inh_q[k] && |(evt_q & event_i);
    assign rd_lo[k]  = cnt_q[31:0];
    assign rd_evt[k] = 32'(evt_q);

`ifdef IBEX_HPM_OVF_IRQ_EN
    assign wrap[k] = inc[k] && !wr_lo && !wr_hi && (&cnt_q);
`endif

    // A CSR write to either half takes priority and suppresses that cycle's increment.
    always_comb begin
      if (wr_lo) begin
        cnt_d = lo_repl;
      end else if (wr_hi) begin
        cnt_d = hi_repl;
      end else if (inc[k]) begin
        cnt_d = cnt_q + CounterWidth'(1);
      end else begin
        cnt_d = cnt_q;
      end
      evt_d = wr_evt ? csr_wdata_i[NumEvents-1:0] : evt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        evt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        evt_q <= evt_d;
      end
    end
  end

  assign inh_word = 32'({inh_q, 3'b000});

  always_comb begin
    inh_d = inh_q;
    if (csr_we_i && is_inh) begin
      inh_d = csr_wdata_i[NumCounters+2:3];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inh_q <= '0;
    end else begin
      inh_q <= inh_d;
    end
  end

`ifdef IBEX_HPM_OVF_IRQ_EN
  // A wrap in the same cycle as a write-1-to-clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (csr_we_i && is_ovf) begin
      ovf_d = ovf_q & ~csr_wdata_i[NumCounters+2:3];
    end
    ovf_d     = ovf_d | wrap;
    ovf_irq_d = |ovf_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q     <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_irq_q <= ovf_irq_d;
    end
  end

  assign ovf_irq_o = ovf_irq_q;
`else
  assign ovf_irq_o = 1'b0;
`endif

  // Unimplemented counter slots in the windows still hit and read zero.
  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = 1'b0;
    if (is_inh) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = inh_word;
    end else if (is_evt || is_lo || is_hi) begin
      csr_hit_o = 1'b1;
      for (int k = 0; k < NumCounters; k++) begin
        if (sel == 5'(k + 3)) begin
          if (is_evt) begin
            csr_rdata_o = rd_evt[k];
          end else if (is_lo) begin
            csr_rdata_o = rd_lo[k];
          end else begin
            csr_rdata_o = rd_hi[k];
          end
        end
      end
`ifdef IBEX_HPM_OVF_IRQ_EN
    end else if (is_ovf) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = 32'({ovf_q, 3'b000});
`endif
    end
  end

endmodule

// File: tb/tb_ibex_hpm_unit.sv
// Randomised bench for ibex_hpm_unit against an arithmetic model of the counter bank.
// Honours IBEX_HPM_OVF_IRQ_EN the same way the design does.
module tb_ibex_hpm_unit;
  localparam int N  = 10;
  localparam int CW = 40;
  localparam int NE = 16;
`ifdef IBEX_HPM_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [31:0] IMPL = ((32'h1 << N) - 32'h1) << 3;
  localparam logic [63:0] MOD  = 64'h1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] ev = '0;
  logic          we = 1'b0;
  logic [11:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          hit;
  logic          irq;

  always #5 clk = ~clk;

  ibex_hpm_unit #(
    .NumCounters (N),
    .CounterWidth(CW),
    .NumEvents   (NE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .event_i    (ev),
    .csr_we_i   (we),
    .csr_addr_i (addr),
    .csr_wdata_i(wdata),
    .csr_rdata_o(rdata),
    .csr_hit_o  (hit),
    .ovf_irq_o  (irq)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic [63:0] m_cnt[N];
  logic [31:0] m_evt[N];
  logic [31:0] m_inh;
  logic [31:0] m_ovf;
  logic        m_irq;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [32:0] exp_read(input logic [11:0] a);
    int ai;
    int idx;
    ai = int'(a);
    if (ai == 'h320) return {1'b1, m_inh};
    if (ai >= 'h323 && ai <= 'h33F) begin
      idx = ai - 'h323;
      if (idx < N) return {1'b1, m_evt[idx]};
      return {1'b1, 32'h0};
    end
    if (ai >= 'hB03 && ai <= 'hB1F) begin
      idx = ai - 'hB03;
      if (idx < N) return {1'b1, m_cnt[idx][31:0]};
      return {1'b1, 32'h0};
    end
    if (ai >= 'hB83 && ai <= 'hB9F) begin
      idx = ai - 'hB83;
      if (idx < N) return {1'b1, m_cnt[idx][63:32]};
      return {1'b1, 32'h0};
    end
    if (OVF_EN && ai == 'h7C2) return {1'b1, m_ovf};
    return 33'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = '0;
      m_evt[k] = '0;
    end
    m_inh = '0;
    m_ovf = '0;
    m_irq = 1'b0;
  endtask

  // Next state from the inputs present at this rising edge.
  task automatic model_step();
    int          ai;
    logic [31:0] wrapped;
    logic [31:0] clr;
    logic        nirq;
    if (rst) begin
      model_reset();
      return;
    end
    ai      = int'(addr);
    wrapped = '0;
    clr     = '0;
    nirq    = (m_ovf != 0);
    for (int k = 0; k < N; k++) begin
      if (we && ai == 'hB03 + k) begin
        m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | {32'h0, wdata};
      end else if (we && ai == 'hB83 + k) begin
        m_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF) | (({32'h0, wdata} << 32) % MOD);
      end else if (!m_inh[k+3] && ((m_evt[k] & 32'(ev)) != 0)) begin
        m_cnt[k] = (m_cnt[k] + 64'h1) % MOD;
        if (m_cnt[k] == 0) wrapped[k+3] = 1'b1;
      end
    end
    if (we && ai == 'h320) m_inh = wdata & IMPL;
    for (int k = 0; k < N; k++) begin
      if (we && ai == 'h323 + k) m_evt[k] = wdata & 32'h0000_FFFF;
    end
    if (we && ai == 'h7C2) clr = wdata & IMPL;
    m_ovf = (m_ovf & ~clr) | wrapped;
    m_irq = OVF_EN && nirq;
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (chk_en) begin
      e = exp_read(addr);
      check("rdata", {32'h0, rdata}, {32'h0, e[31:0]});
      check("hit", {63'h0, hit}, {63'h0, e[32]});
      check("irq", {63'h0, irq}, {63'h0, m_irq});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, input string nm, input logic [31:0] exp, input logic exph);
    we = 1'b0;
    addr = a;
    #1;
    check(nm, {32'h0, rdata}, {32'h0, exp});
    check({nm, "_hit"}, {63'h0, hit}, {63'h0, exph});
  endtask

  initial begin
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    peek(12'hB03, "rst_cnt3", 32'h0, 1'b1);
    peek(12'h323, "rst_evt3", 32'h0, 1'b1);
    check("rst_irq", {63'h0, irq}, 64'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    ev = 16'h0001;
    repeat (5) tick();
    ev = '0;
    peek(12'hB03, "no_evt_sel", 32'h0, 1'b1);

    wr(12'h323, 32'h3);
    ev = 16'h0003;
    repeat (4) tick();
    ev = '0;
    peek(12'hB03, "multi_evt", 32'h4, 1'b1);

    ev = 16'h0001;
    tick();
    wr(12'hB03, 32'h10);
    peek(12'hB03, "wr_lo", 32'h10, 1'b1);
    tick();
    ev = '0;
    peek(12'hB03, "wr_lo_inc", 32'h11, 1'b1);
    peek(12'hB83, "hi_keep", 32'h0, 1'b1);

    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    peek(12'hB83, "hi_ff", 32'hFF, 1'b1);
    ev = 16'h0001;
    tick();
    ev = '0;
    peek(12'hB03, "wrap_lo", 32'h0, 1'b1);
    peek(12'hB83, "wrap_hi", 32'h0, 1'b1);
`ifdef IBEX_HPM_OVF_IRQ_EN
    peek(12'h7C2, "ovf_flag", 32'h8, 1'b1);
    check("irq_lag", {63'h0, irq}, 64'h0);
    tick();
    check("irq_set", {63'h0, irq}, 64'h1);
    wr(12'h7C2, 32'h8);
    check("irq_hold", {63'h0, irq}, 64'h1);
    tick();
    check("irq_clr", {63'h0, irq}, 64'h0);
`else
    peek(12'h7C2, "ovf_nohit", 32'h0, 1'b0);
    check("irq_off", {63'h0, irq}, 64'h0);
`endif

    wr(12'h324, 32'h1);
    wr(12'hB03, 32'h0);
    wr(12'hB04, 32'h0);
    ev = 16'h0001;
    wr(12'h320, 32'h10);
    tick();
    tick();
    ev = '0;
    peek(12'hB03, "inh_c3", 32'h3, 1'b1);
    peek(12'hB04, "inh_c4", 32'h1, 1'b1);
    peek(12'h320, "inh_rd", 32'h10, 1'b1);

    wr(12'h320, 32'hFFFF_FFFF);
    peek(12'h320, "inh_impl", IMPL, 1'b1);
    wr(12'h320, 32'h0);
    wr(12'hB0D, 32'h5);
    peek(12'hB0D, "unimpl_wr", 32'h0, 1'b1);
    peek(12'hB1F, "unimpl", 32'h0, 1'b1);
    tick();
    peek(12'h321, "gap_321", 32'h0, 1'b0);
    peek(12'hB02, "gap_b02", 32'h0, 1'b0);
    peek(12'hB9F, "unimpl_hi", 32'h0, 1'b1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      ev = ($urandom_range(0, 3) == 0) ? '0 : NE'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0:       addr = 12'h320;
        1, 2:    addr = 12'(12'h323 + $urandom_range(0, 12));
        3, 4:    addr = 12'(12'hB03 + $urandom_range(0, 12));
        5, 6:    addr = 12'(12'hB83 + $urandom_range(0, 12));
        7:       addr = 12'h7C2;
        8:       addr = 12'($urandom);
        default: addr = 12'hB1F;
      endcase
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       wdata = $urandom;
        1:       wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        2:       wdata = 32'hFF;
        default: wdata = $urandom & 32'h0000_FFFF;
      endcase
      tick();
    end
    we = 1'b0;

    ev = 16'hFFFF;
    rst = 1'b1;
    #1;
    model_reset();
    peek(12'hB03, "async_rst_cnt", 32'h0, 1'b1);
    peek(12'h323, "async_rst_evt", 32'h0, 1'b1);
    check("async_rst_irq", {63'h0, irq}, 64'h0);
    tick();
    rst = 1'b0;
    ev = '0;
    wr(12'h323, 32'h1);
    ev = 16'h0001;
    tick();
    tick();
    ev = '0;
    peek(12'hB03, "resume", 32'h2, 1'b1);

    for (int i = 0; i < 200; i++) begin
      ev = NE'($urandom);
      addr = 12'(12'hB03 + $urandom_range(0, 12));
      we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      tick();
    end
    we = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
